// File: rtl/test_harness.sv
// test_harness: self-checking memory test for simulation.
// Fills a DEPTH x 32 scratch RAM with a 32-bit LFSR sequence (x^32+x^22+x^2+x+1),
// reads it back against a regenerated copy of the sequence, and raises a sticky
// io_success when every word matches.
// Optional build macro TEST_HARNESS_ERR_INJECT_EN: flips bit 0 of the word written
// to address 5 so the read-back fails and io_success never rises.
module test_harness #(
    parameter int          ADDR_W = 6,
    parameter logic [31:0] SEED   = 32'h0000_0001
) (
    input  logic clock,
    input  logic reset,
    output logic io_success
);

    localparam int              DATA_W = 32;
    localparam int              DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {S_WRITE, S_READ, S_DONE, S_FAIL} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_lfsr;
    logic [DATA_W-1:0]   r_lfsr_d;
    logic                r_error;
    logic                r_issue_done;
    logic                r_rd_valid;
    logic                r_rd_last;
    logic                r_cmp_last;
    logic                r_success;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_data;

    logic                w_wr_en;
    logic                w_rd_en;
    logic [DATA_W-1:0]   w_wr_data;
    logic [DATA_W-1:0]   w_lfsr_next;
    logic                w_mismatch;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
        return {v[DATA_W-2:0], 1'b0} ^ (v[DATA_W-1] ? 32'h0040_0007 : 32'h0000_0000);
    endfunction

    assign w_lfsr_next = lfsr_step(r_lfsr);

    // RAM traffic is gated by reset so an asserted reset never disturbs contents.
    assign w_wr_en = reset && (r_state == S_WRITE);
    assign w_rd_en = reset && (r_state == S_READ) && !r_issue_done;

`ifdef TEST_HARNESS_ERR_INJECT_EN
    assign w_wr_data = r_lfsr ^ ((32'(r_addr) == 32'd5) ? 32'h0000_0001 : 32'h0000_0000);
`else
    assign w_wr_data = r_lfsr;
`endif

    // Read data is compared against the LFSR value captured alongside the read.
    assign w_mismatch = (r_rd_data != r_lfsr_d);

    // Scratch RAM: single write port, registered read port (no reset, block RAM style).
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_addr] <= w_wr_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_addr];
        end
    end

    // Test sequencer: write pass, read/compare pass with a 1-cycle pipeline, terminal verdict.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_WRITE;
            r_addr       <= '0;
            r_lfsr       <= SEED;
            r_lfsr_d     <= SEED;
            r_error      <= 1'b0;
            r_issue_done <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_cmp_last   <= 1'b0;
            r_success    <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_cmp_last <= 1'b0;
            case (r_state)
                S_WRITE: begin
                    if (r_addr == LAST) begin
                        r_addr       <= '0;
                        r_lfsr       <= SEED;
                        r_issue_done <= 1'b0;
                        r_state      <= S_READ;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_lfsr <= w_lfsr_next;
                    end
                end
                S_READ: begin
                    // Issue stage: one read per cycle; counter parks at the last address.
                    if (!r_issue_done) begin
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= (r_addr == LAST);
                        r_lfsr_d   <= r_lfsr;
                        r_lfsr     <= w_lfsr_next;
                        if (r_addr == LAST) begin
                            r_issue_done <= 1'b1;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                    // Compare stage: one cycle behind the issue stage.
                    if (r_rd_valid) begin
                        if (w_mismatch) begin
                            r_error <= 1'b1;
                        end
                        r_cmp_last <= r_rd_last;
                    end
                    // Verdict one cycle after the final compare, so it sees its error.
                    if (r_cmp_last) begin
                        r_state   <= r_error ? S_FAIL : S_DONE;
                        r_success <= !r_error;
                    end
                end
                S_DONE: r_success <= 1'b1;
                S_FAIL: r_success <= 1'b0;
            endcase
        end
    end

    assign io_success = r_success;

endmodule

// File: tb/tb_test_harness.sv
// Bench for test_harness: runs a default-size instance and a DEPTH=4 instance
// side by side on a shared clock and reset, predicting io_success from the
// number of edges since the last reset release, and checking RAM contents
// against a bench-side LFSR model.
`timescale 1ns/1ps
module tb_test_harness;

`ifdef TEST_HARNESS_ERR_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic clock;
    logic reset;
    logic succ_main;
    logic succ_small;

    int checks   = 0;
    int failures = 0;
    int since    = 0;   // rising edges sampling reset high since last reset edge

    typedef struct {
        string tag;
        logic  exp_main;
        logic  exp_small;
    } exp_t;
    exp_t sb_q[$];

    test_harness dut (
        .clock      (clock),
        .reset      (reset),
        .io_success (succ_main)
    );

    test_harness #(.ADDR_W(2), .SEED(32'h8000_0000)) dut_small (
        .clock      (clock),
        .reset      (reset),
        .io_success (succ_small)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] model_step(input logic [31:0] v);
        logic [31:0] n;
        n = {v[30:0], 1'b0};
        if (v[31]) n = n ^ 32'h0040_0007;
        return n;
    endfunction

    // Drive reset for one edge, push the predicted outputs, then compare after the edge.
    task automatic tick(input string tag, input logic rst_val);
        exp_t e;
        @(negedge clock);
        reset = rst_val;
        if (!rst_val) since = 0;
        else          since = since + 1;
        e.tag       = tag;
        e.exp_main  = (since >= 130) && !INJ;
        e.exp_small = (since >= 10);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        checks++;
        assert (succ_main === e.exp_main) else begin
            failures++;
            $error("FAIL %s main edge=%0d io_success=%b expected=%b", e.tag, since, succ_main, e.exp_main);
        end
        checks++;
        assert (succ_small === e.exp_small) else begin
            failures++;
            $error("FAIL %s small edge=%0d io_success=%b expected=%b", e.tag, since, succ_small, e.exp_small);
        end
        $display("tick %s edge=%0d main=%b small=%b", e.tag, since, succ_main, succ_small);
    endtask

    task automatic check_word(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
        $display("ram %s got=%h expected=%h", tag, got, exp);
    endtask

    initial begin
        logic [31:0] m;
        logic [31:0] w;
        reset = 1'b0;

        // Reset held low for three edges.
        for (int i = 0; i < 3; i++) tick("reset", 1'b0);

        // Full run to edge 1000.
        for (int i = 0; i < 1000; i++) tick("run", 1'b1);

        // RAM contents, default instance, against the model and fixed constants.
        m = 32'h0000_0001;
        for (int a = 0; a < 64; a++) begin
            w = m;
            if (INJ && a == 5) w = w ^ 32'h0000_0001;
            check_word($sformatf("main_addr%0d", a), dut.r_mem[a], w);
            m = model_step(m);
        end
        check_word("main_addr0_const",  dut.r_mem[0],  32'h0000_0001);
        check_word("main_addr1_const",  dut.r_mem[1],  32'h0000_0002);
        check_word("main_addr31_const", dut.r_mem[31], 32'h8000_0000);
        check_word("main_addr32_const", dut.r_mem[32], 32'h0040_0007);
        check_word("small_addr0_const", dut_small.r_mem[0], 32'h8000_0000);
        check_word("small_addr1_const", dut_small.r_mem[1], 32'h0040_0007);

        // Reset while in DONE, then release and run again.
        tick("reset_in_done", 1'b0);
        for (int i = 0; i < 135; i++) tick("rerun", 1'b1);

        // Fresh start, then reset pulsed on edge 70 (mid-READ).
        tick("reset_pre_mid", 1'b0);
        for (int i = 0; i < 69; i++) tick("pre_mid", 1'b1);
        tick("reset_mid_read", 1'b0);
        for (int i = 0; i < 135; i++) tick("post_mid", 1'b1);

        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/test_harness.md
# test_harness

Self-checking top-level harness for simulation. It holds an on-chip scratch RAM and runs a built-in write/read-back memory test driven by a 32-bit LFSR. It raises `io_success` once every word reads back correctly. The enclosing simulation driver watches `io_success` to end the run, and treats a missing `io_success` before its cycle limit as a failure.

## Interface
- `ADDR_W`, default 6: scratch RAM address width; DEPTH = 2^ADDR_W words.
- `DATA_W`, fixed 32: word width. Not user-changeable; the LFSR is 32 bits.
- `SEED`, default 32'h0000_0001: LFSR start value. Must be nonzero.
- `clock`  in  1  sole clock, rising-edge.
- `reset`  in  1  reset, synchronous, active-low; clock clock.
- `io_success`  out  1  registered; high = test passed; sticky until reset.

## Operation
- LFSR step: next = (lfsr << 1) ^ (lfsr[31] ? 32'h0040_0007 : 0).
  - This is polynomial x^32+x^22+x^2+x+1, maximal length.
- Data for address a is the LFSR value after a steps from SEED.
- Internal RAM: DEPTH x 32, one write port, one read port with a 1-cycle registered read.
- FSM states: WRITE, READ, DONE, FAIL.
- WRITE:
  - Address counter runs 0..DEPTH-1, one write per cycle of the current LFSR value; LFSR steps each cycle.
  - After address DEPTH-1: reload LFSR with SEED, clear the address counter, go to READ.
- READ:
  - Issue one read per cycle, addresses 0..DEPTH-1.
  - Each returned word is compared one cycle later with the regenerated LFSR value, which is delayed one cycle to align with the read data.
  - Any mismatch sets a sticky error flag.
- After the last compare: go to DONE if the error flag is clear, else FAIL.
- DONE: `io_success`=1 and held.
- FAIL: `io_success`=0 forever; the driver times out and reports failure.
- DONE and FAIL are terminal; only reset leaves them.

## Timing
- While reset is low on an edge:
  - state←WRITE, address←0, LFSR←SEED, error←0, `io_success`←0.
  - RAM contents are not cleared.
- Edge numbering: edge 1 is the first rising edge that samples reset high.
- Writes occur on edges 1..DEPTH.
- Read addresses are issued on edges DEPTH+1..2·DEPTH.
- Compares occur on edges DEPTH+2..2·DEPTH+1.
- The state goes to DONE/FAIL on edge 2·DEPTH+2. `io_success` is high after that edge (edge 130 for DEPTH=64).
- Reset asserted mid-test (any state): the test restarts from WRITE at address 0 and `io_success` drops on that edge.
- A compare on the final address (DEPTH-1) counts like any other. Address wrap-around never occurs because the counters stop at DEPTH-1.
- `io_success` never glitches: it is driven directly from a flop.

## Configuration
- `TEST_HARNESS_ERR_INJECT_EN`
  - Defined: the word written to address 5 has bit 0 inverted. The read-back of address 5 mismatches, the FSM ends in FAIL, and `io_success` stays 0.
  - Undefined: data is written unmodified and a correct design reaches DONE.
- The FSM, timing and ports are identical in both builds.

## Test plan
- Defaults, macro undefined, reset low for 3 edges then high → `io_success`=0 through edge 129, 1 after edge 130, still 1 at edge 1000.
- Defaults: check the RAM contents written.
  - Address 0 = 32'h0000_0001, address 1 = 32'h0000_0002, address 31 = 32'h8000_0000.
  - Address 32 = 32'h0040_0007.
- Macro defined, defaults → `io_success` stays 0 through edge 10000. FSM in FAIL after edge 130.
- Reset pulled low for one edge at edge 70, mid-READ, then released → `io_success`=0 until 130 edges after the release, then 1.
- Reset asserted while in DONE → `io_success`=0 after that edge. After release, `io_success`=1 again 130 edges later.
- `ADDR_W`=2 (DEPTH=4), SEED=32'h8000_0000 → `io_success` high after edge 10. RAM address 1 = 32'h0040_0007.
